bus_arb: RTL and testbench
==========================

Name: bus_arb

Overview:
- Two-master arbiter that shares the single ECO32 bus (en/wr/size/addr/data/wt protocol) between the CPU (master 0) and a DMA-capable master (master 1, e.g. disk or display fetch).
- Sits between the masters and busctrl; busctrl sees one master.
- Fixed priority to master 0, with a burst limit so master 1 cannot starve.
- Grant is held for the whole of each transfer.

Parameters:
MAX_BURST, 4, consecutive completed master-0 transfers allowed while master 1 waits before a forced switch (1..255)
TIMEOUT_CYCLES, 1024, bus_wt-high cycles before abort (only with BUS_ARB_TIMEOUT_EN; 2..65535)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
m0_en / m1_en  in  1  master n requests a transfer; held until completion
m0_wr / m1_wr  in  1  master n write (1) / read (0)
m0_size / m1_size  in  2  master n transfer size; passed through unchanged
m0_addr / m1_addr  in  32  master n address
m0_data_out / m1_data_out  in  32  master n write data
m0_data_in / m1_data_in  out  32  read data to master n
m0_wt / m1_wt  out  1  wait to master n; 0 marks completion
bus_en  out  1  to busctrl cpu_en
bus_wr  out  1  to busctrl cpu_wr
bus_size  out  2  to busctrl cpu_size
bus_addr  out  32  to busctrl cpu_addr
bus_data_out  out  32  write data to busctrl
bus_data_in  in  32  read data from busctrl
bus_wt  in  1  wait from busctrl
bus_timeout  out  1  one-cycle abort pulse (tied 0 without macro)

Behaviour:
- States: IDLE, G0, G1, ABORT. All registered; reset forces IDLE and clears burst counter and timer.
- bus_en = (state==G0 & m0_en) | (state==G1 & m1_en). wr/size/addr/data_out mux from the owner; from m0 in IDLE/ABORT.
- Reset value of outputs:
  - bus_en=0, bus_timeout=0, mN_data_in=0.
  - mN_wt=1 whenever mN_en=1 (0 when mN_en=0).
- mN_wt: 0 only in the completion cycle (state==Gn & mN_en & !bus_wt), or when mN_en=0; otherwise 1.
- mN_data_in = bus_data_in in the owner's completion cycle, else 0.
- Arbitration happens at IDLE, at a completion edge, and in Gn when mN_en=0:
  - only one master requesting: it wins;
  - both requesting: m0 wins unless burst_cnt==MAX_BURST, then m1 wins;
  - neither requesting: IDLE.
- Arbitration at a completion edge uses the other master's en and the owner's en; back-to-back owner transfers need no bubble.
- Latency: request in IDLE at cycle t → grant at t+1 → bus_en at t+1. With a zero-wait slave, completion is at t+1.
- burst_cnt:
  - +1 per m0 completion while m1_en=1, saturating at MAX_BURST;
  - cleared on any m1 completion or when m1_en=0.
- Owner dropping en mid-transfer (protocol violation): bus_en drops the same cycle and arbitration proceeds. No spurious completion is signalled.
- Simultaneous first requests from IDLE: m0 granted.
- Reset asserted mid-transfer: state goes to IDLE asynchronously, bus_en=0 immediately, the outstanding transfer is lost.

Optional Feature:
BUS_ARB_TIMEOUT_EN
- With the macro:
  - 16-bit timer counts cycles with bus_en & bus_wt; cleared at each completion or when bus_en=0.
  - At count TIMEOUT_CYCLES-1 with bus_wt still 1: owner gets mN_wt=0 and mN_data_in=0 that cycle, bus_timeout=1 for one cycle.
  - State then enters ABORT for one cycle (bus_en=0, both wt follow the rule above), then arbitrates.
  - An abort counts as a completion for burst_cnt.
- Without the macro: no timer, no ABORT state, bus_timeout tied 0, wt waits indefinitely.

Decomposition:
- Shared package eco32_bus_pkg holds:
  - state encoding (IDLE=0, G0=1, G1=2, ABORT=3);
  - bus size constants;
  - widths BUS_AW=32, BUS_DW=32.
- One natural sub-module: bus_arb_tmr (timeout counter plus compare, instantiated only under the macro).
- Arbitration, mux and burst counter stay in the top module.

Test Plan:
- m1 alone, read of addr 0x30000000, bus_wt high 3 cycles, bus_data_in=0xDEADBEEF → bus_en at t+1, m1_wt=0 at t+4, m1_data_in=0xDEADBEEF that cycle only, m0_data_in=0.
- m0 and m1 raise en in the same cycle, zero-wait slave → m0 completes first. m1 is granted on the next cycle and completes one cycle later.
- m0 streams continuously, m1 held at en=1, MAX_BURST=4 → exactly 4 m0 completions, then one m1 completion, then m0 resumes. burst_cnt returns to 0.
- m0 write 0x12345678 to 0x30100004, size=2 → bus_wr=1, bus_addr/bus_data_out/bus_size match, mux never toggles mid-transfer.
- With BUS_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, bus_wt stuck at 1 → m0_wt=0 with m0_data_in=0 in the 8th bus_en cycle, bus_timeout pulses once, bus_en low for one ABORT cycle.
- Reset pulsed while G1 owns the bus with bus_wt=1 → bus_en=0 asynchronously, state IDLE. After release, m0 is granted first if both request.

Source files
------------

// File: rtl/eco32_bus_pkg.sv
// Shared ECO32 bus definitions: widths, size codes, arbiter state encoding.
// Used by bus_arb and bus_arb_tmr.
package eco32_bus_pkg;

  localparam int BUS_AW = 32;
  localparam int BUS_DW = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_G0    = 2'd1,
    ST_G1    = 2'd2,
    ST_ABORT = 2'd3
  } arb_st_t;

  // Fixed priority to master 0 unless the burst limit is reached.
  function automatic arb_st_t arb_pick(
    input logic r0,
    input logic r1,
    input logic full
  );
    if (r0 && !(r1 && full)) return ST_G0;
    else if (r1) return ST_G1;
    else return ST_IDLE;
  endfunction

  function automatic logic size_ok(input logic [1:0] s);
    return (s == SZ_BYTE) || (s == SZ_HALF) || (s == SZ_WORD);
  endfunction

endpackage

// File: rtl/bus_arb_tmr.sv
// Bus wait-state watchdog for bus_arb; only built with BUS_ARB_TIMEOUT_EN.
// Counts cycles of an active, stalled transfer and flags the last one.
module bus_arb_tmr
  import eco32_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic bus_en,
  input  logic bus_wt,
  output logic hit
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt;

  assign hit = bus_en & bus_wt & (cnt == LIMIT);

  // Count stalled cycles; restart on completion, idle bus or abort.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!bus_en || !bus_wt || hit) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/bus_arb.sv
// Two-master ECO32 bus arbiter: m0 (CPU) has priority, m1 is burst-protected.
// Optional stall abort enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arb
  import eco32_bus_pkg::*;
#(
  parameter int MAX_BURST      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_en,
  input  logic              m0_wr,
  input  logic [1:0]        m0_size,
  input  logic [BUS_AW-1:0] m0_addr,
  input  logic [BUS_DW-1:0] m0_data_out,
  output logic [BUS_DW-1:0] m0_data_in,
  output logic              m0_wt,
  input  logic              m1_en,
  input  logic              m1_wr,
  input  logic [1:0]        m1_size,
  input  logic [BUS_AW-1:0] m1_addr,
  input  logic [BUS_DW-1:0] m1_data_out,
  output logic [BUS_DW-1:0] m1_data_in,
  output logic              m1_wt,
  output logic              bus_en,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [BUS_AW-1:0] bus_addr,
  output logic [BUS_DW-1:0] bus_data_out,
  input  logic [BUS_DW-1:0] bus_data_in,
  input  logic              bus_wt,
  output logic              bus_timeout
);

  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_burst
    $error("bus_arb: MAX_BURST out of range");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_tmo
    $error("bus_arb: TIMEOUT_CYCLES out of range");
  end

  arb_st_t    state;
  arb_st_t    state_nxt;
  arb_st_t    pick;
  logic [7:0] burst_cnt;
  logic [7:0] burst_nxt;

  logic g0;
  logic g1;
  logic done0;
  logic done1;
  logic abort;
  logic abort0;
  logic abort1;
  logic fin0;
  logic fin1;

  assign g0 = (state == ST_G0);
  assign g1 = (state == ST_G1);

  assign bus_en = (g0 & m0_en) | (g1 & m1_en);

  assign done0 = g0 & m0_en & ~bus_wt;
  assign done1 = g1 & m1_en & ~bus_wt;

`ifdef BUS_ARB_TIMEOUT_EN
  bus_arb_tmr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmr (
    .clk   (clk),
    .reset (reset),
    .bus_en(bus_en),
    .bus_wt(bus_wt),
    .hit   (abort)
  );
`else
  assign abort = 1'b0;
`endif

  assign abort0 = abort & g0;
  assign abort1 = abort & g1;
  assign fin0   = done0 | abort0;
  assign fin1   = done1 | abort1;

  assign bus_timeout = abort;

  assign m0_wt = m0_en & ~fin0;
  assign m1_wt = m1_en & ~fin1;

  assign m0_data_in = done0 ? bus_data_in : '0;
  assign m1_data_in = done1 ? bus_data_in : '0;

  assign bus_wr       = g1 ? m1_wr       : m0_wr;
  assign bus_size     = g1 ? m1_size     : m0_size;
  assign bus_addr     = g1 ? m1_addr     : m0_addr;
  assign bus_data_out = g1 ? m1_data_out : m0_data_out;

  // Burst counter: m0 completions while m1 waits, saturating.
  always_comb begin
    burst_nxt = burst_cnt;
    if (!m1_en || fin1) begin
      burst_nxt = '0;
    end else if (fin0 && burst_cnt != BURST_MAX) begin
      burst_nxt = burst_cnt + 8'd1;
    end
  end

  assign pick = arb_pick(m0_en, m1_en, burst_nxt == BURST_MAX);

  // Next owner: re-arbitrate when idle, on completion, or on dropped request.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  state_nxt = pick;
      ST_ABORT: state_nxt = pick;
      ST_G0: begin
        if (abort0) state_nxt = ST_ABORT;
        else if (!m0_en || done0) state_nxt = pick;
      end
      ST_G1: begin
        if (abort1) state_nxt = ST_ABORT;
        else if (!m1_en || done1) state_nxt = pick;
      end
    endcase
  end

  // Owner state and burst count registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_nxt;
    end
  end

endmodule

// File: tb/tb_bus_arb.sv
// Scoreboard bench for bus_arb: master/slave models, ordered completions.
// Abort scenario runs only when BUS_ARB_TIMEOUT_EN is defined.
module tb_bus_arb;
  import eco32_bus_pkg::*;

  localparam int MAXB = 4;
  localparam int TMO  = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_en, m0_wr, m0_wt;
  logic [1:0]  m0_size;
  logic [31:0] m0_addr, m0_data_out, m0_data_in;
  logic        m1_en, m1_wr, m1_wt;
  logic [1:0]  m1_size;
  logic [31:0] m1_addr, m1_data_out, m1_data_in;
  logic        bus_en, bus_wr, bus_wt, bus_timeout;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_data_out, bus_data_in;

  bus_arb #(
    .MAX_BURST     (MAXB),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .m0_en       (m0_en),
    .m0_wr       (m0_wr),
    .m0_size     (m0_size),
    .m0_addr     (m0_addr),
    .m0_data_out (m0_data_out),
    .m0_data_in  (m0_data_in),
    .m0_wt       (m0_wt),
    .m1_en       (m1_en),
    .m1_wr       (m1_wr),
    .m1_size     (m1_size),
    .m1_addr     (m1_addr),
    .m1_data_out (m1_data_out),
    .m1_data_in  (m1_data_in),
    .m1_wt       (m1_wt),
    .bus_en      (bus_en),
    .bus_wr      (bus_wr),
    .bus_size    (bus_size),
    .bus_addr    (bus_addr),
    .bus_data_out(bus_data_out),
    .bus_data_in (bus_data_in),
    .bus_wt      (bus_wt),
    .bus_timeout (bus_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        abrt;
  } exp_t;

  txn_t mq0[$], mq1[$];
  exp_t eq0[$], eq1[$];
  int   oq[$];

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  int ld0, ld1, comp0, comp1, rise;
  int n_tmo = 0;
  logic [31:0] last_rd1;

  bit c0, c1, flush, stuck, adv;
  int wait_n = 0;
  int wcnt   = 0;

  bit          pv, pe, pw;
  logic [31:0] pa, pd;
  txn_t        t0, t1;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] slv_rd(logic [31:0] a);
    return a ^ 32'hEEAD_BEEF;
  endfunction

  assign bus_wt      = stuck || (wcnt < wait_n);
  assign bus_data_in = bus_en ? slv_rd(bus_addr) : 32'h0;

  task automatic push(int id, logic wr, logic [1:0] sz,
                      logic [31:0] a, logic [31:0] d, bit ab);
    txn_t t;
    exp_t e;
    t.wr = wr; t.size = sz; t.addr = a; t.data = d;
    e.wr = wr; e.size = sz; e.addr = a; e.wdata = d;
    e.rdata = ab ? 32'h0 : slv_rd(a);
    e.abrt = ab;
    if (id == 0) begin mq0.push_back(t); eq0.push_back(e); end
    else begin mq1.push_back(t); eq1.push_back(e); end
  endtask

  task automatic complete(int id);
    exp_t e;
    int   o;
    o = (oq.size() > 0) ? oq.pop_front() : -1;
    check("order", o, id);
    if ((id == 0 && eq0.size() == 0) || (id == 1 && eq1.size() == 0)) begin
      check("sb_avail", (id == 0) ? eq0.size() : eq1.size(), 1);
      return;
    end
    e = (id == 0) ? eq0.pop_front() : eq1.pop_front();
    check("addr", bus_addr, e.addr);
    check("wr", 32'(bus_wr), 32'(e.wr));
    check("size", 32'(bus_size), 32'(e.size));
    if (e.wr) check("wdata", bus_data_out, e.wdata);
    check("rdata", (id == 0) ? m0_data_in : m1_data_in, e.rdata);
    check("xdata", (id == 0) ? m1_data_in : m0_data_in, 32'h0);
    check("tmo", 32'(bus_timeout), 32'(e.abrt));
    if (id == 0) comp0 = cyc;
    else begin comp1 = cyc; last_rd1 = m1_data_in; end
  endtask

  task automatic drain(string tag, int lim);
    int k = 0;
    while ((oq.size() + eq0.size() + eq1.size() + mq0.size()
            + mq1.size() > 0 || m0_en || m1_en) && k < lim) begin
      @(posedge clk);
      k++;
    end
    check(tag, oq.size() + eq0.size() + eq1.size(), 0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // master 0
  initial begin
    m0_en = 0; m0_wr = 0; m0_size = 0; m0_addr = 0; m0_data_out = 0;
    forever begin
      @(posedge clk); #1;
      if (flush) begin
        m0_en = 0; mq0.delete();
      end else begin
        if (m0_en && c0) m0_en = 0;
        if (!m0_en && mq0.size() > 0) begin
          t0 = mq0.pop_front();
          m0_wr = t0.wr; m0_size = t0.size;
          m0_addr = t0.addr; m0_data_out = t0.data;
          m0_en = 1; ld0 = cyc;
        end
      end
    end
  end

  // master 1
  initial begin
    m1_en = 0; m1_wr = 0; m1_size = 0; m1_addr = 0; m1_data_out = 0;
    forever begin
      @(posedge clk); #1;
      if (flush) begin
        m1_en = 0; mq1.delete();
      end else begin
        if (m1_en && c1) m1_en = 0;
        if (!m1_en && mq1.size() > 0) begin
          t1 = mq1.pop_front();
          m1_wr = t1.wr; m1_size = t1.size;
          m1_addr = t1.addr; m1_data_out = t1.data;
          m1_en = 1; ld1 = cyc;
        end
      end
    end
  end

  // slave wait counter
  initial forever begin
    @(posedge clk); #1;
    wcnt = adv ? wcnt + 1 : 0;
  end

  // monitor
  initial forever begin
    @(negedge clk);
    c0 = m0_en && !m0_wt;
    c1 = m1_en && !m1_wt;
    if (c0) complete(0);
    if (c1) complete(1);
    if (m0_en && m0_wt) check("idle_rd0", m0_data_in, 32'h0);
    if (m1_en && m1_wt) check("idle_rd1", m1_data_in, 32'h0);
    if (bus_en && pv) begin
      check("hold_addr", bus_addr, pa);
      check("hold_wdat", bus_data_out, pd);
      check("hold_wr", 32'(bus_wr), 32'(pw));
    end
    pv = bus_en && bus_wt && !bus_timeout;
    pa = bus_addr; pd = bus_data_out; pw = bus_wr;
    if (bus_en && !pe) rise = cyc;
    pe  = bus_en;
    adv = bus_en && bus_wt;
    if (bus_timeout) n_tmo++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int k;
    int tm;
    reset = 1; flush = 0; stuck = 0; wait_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_en", 32'(bus_en), 0);
    check("rst_tmo", 32'(bus_timeout), 0);
    check("rst_d0", m0_data_in, 32'h0);
    check("rst_d1", m1_data_in, 32'h0);
    check("rst_wt0", 32'(m0_wt), 0);
    reset = 0;

    // m1 alone, three wait states
    @(negedge clk);
    wait_n = 3;
    push(1, 1'b0, SZ_WORD, 32'h3000_0000, 32'h0, 1'b0);
    oq.push_back(1);
    drain("t1_drain", 50);
    check("t1_grant", rise - ld1, 1);
    check("t1_done", comp1 - ld1, 4);
    check("t1_rd", last_rd1, 32'hDEAD_BEEF);

    // simultaneous first requests
    @(negedge clk);
    wait_n = 0;
    push(0, 1'b0, SZ_WORD, 32'h0000_0100, 32'h0, 1'b0);
    push(1, 1'b0, SZ_HALF, 32'h0000_0200, 32'h0, 1'b0);
    oq.push_back(0); oq.push_back(1);
    drain("t2_drain", 50);
    check("t2_m0_lat", comp0 - ld0, 1);
    check("t2_m1_after", 32'(comp1 > comp0), 1);

    // burst limit with m1 waiting
    @(negedge clk);
    for (int i = 0; i < 10; i++)
      push(0, 1'b0, SZ_WORD, 32'h0000_1000 + 32'(4 * i), 32'h0, 1'b0);
    push(1, 1'b0, SZ_WORD, 32'h2000_0000, 32'h0, 1'b0);
    push(1, 1'b1, SZ_BYTE, 32'h2000_0001, 32'h0000_00A5, 1'b0);
    for (int i = 0; i < 4; i++) oq.push_back(0);
    oq.push_back(1);
    for (int i = 0; i < 4; i++) oq.push_back(0);
    oq.push_back(1);
    oq.push_back(0); oq.push_back(0);
    drain("t3_drain", 100);

    // m0 write with wait states
    @(negedge clk);
    wait_n = 2;
    push(0, 1'b1, SZ_WORD, 32'h3010_0004, 32'h1234_5678, 1'b0);
    oq.push_back(0);
    drain("t4_drain", 50);

`ifdef BUS_ARB_TIMEOUT_EN
    // stalled slave, abort path
    @(negedge clk);
    stuck = 1;
    tm = n_tmo;
    push(0, 1'b0, SZ_WORD, 32'h3020_0000, 32'h0, 1'b1);
    push(0, 1'b0, SZ_WORD, 32'h3020_0004, 32'h0, 1'b0);
    oq.push_back(0); oq.push_back(0);
    k = 0;
    while (!c0 && k < 40) begin @(negedge clk); k++; end
    check("t5_seen", 32'(c0), 1);
    check("t5_cyc", comp0 - rise, TMO - 1);
    @(posedge clk); #1;
    stuck = 0;
    @(negedge clk);
    check("t5_abort_en", 32'(bus_en), 0);
    check("t5_m0_req", 32'(m0_en), 1);
    drain("t5_drain", 50);
    check("t5_pulses", n_tmo - tm, 1);
`endif

    // reset while m1 owns a stalled bus
    @(negedge clk);
    stuck = 1;
    t1.wr = 0; t1.size = SZ_WORD; t1.addr = 32'h3000_0040; t1.data = 0;
    mq1.push_back(t1);
    k = 0;
    while (!bus_en && k < 20) begin @(negedge clk); k++; end
    check("t6_busy", 32'(bus_en), 1);
    @(posedge clk);
    @(negedge clk);
    #2 reset = 1;
    #1;
    check("t6_en", 32'(bus_en), 0);
    check("t6_wt1", 32'(m1_wt), 1);
    flush = 1;
    @(posedge clk); #2;
    flush = 0;
    stuck = 0;
    @(negedge clk);
    reset = 0;
    wait_n = 1;
    push(0, 1'b0, SZ_WORD, 32'h0000_0300, 32'h0, 1'b0);
    push(1, 1'b0, SZ_WORD, 32'h0000_0400, 32'h0, 1'b0);
    oq.push_back(0); oq.push_back(1);
    drain("t6_drain", 50);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
